// File: rtl/fetch_stream.sv
// Instruction-fetch front end: keeps the fetch PC, issues pipelined word requests under a
// credit limit, and returns instructions in order on decode's stall-handshake stream.
module fetch_stream #(
  parameter int              ALEN     = 32,
  parameter int              ILEN     = 32,
  parameter logic [ALEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic [ALEN-1:0] i_flush_addr,
  output logic            o_mem_req_valid,
  input  logic            i_mem_req_ready,
  output logic [ALEN-1:0] o_mem_req_addr,
  input  logic            i_mem_resp_valid,
  input  logic [ILEN-1:0] i_mem_resp_data,
  input  logic            i_mem_resp_error,
  output logic [ILEN-1:0] o_instruction,
  output logic [ALEN-1:0] o_instruction_addr,
  output logic [ALEN-1:0] o_instruction_next_addr,
  output logic            o_ifetch_exception,
  output logic            o_stall_next,
  input  logic            i_next_stalled
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 2;

  typedef enum logic {
    ST_FETCH,
    ST_HALTED
  } state_t;

  state_t          r_state;
  logic [ALEN-1:0] r_pc;
  logic [CW-1:0]   r_inflight;
  logic [CW-1:0]   r_dropCnt;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_wrPtr;
  logic [PW-1:0]   r_rdPtr;
  logic [PW-1:0]   r_aqWr;
  logic [PW-1:0]   r_aqRd;

  logic [ILEN-1:0] r_fifoData [DEPTH];
  logic [ALEN-1:0] r_fifoAddr [DEPTH];
  logic [DEPTH-1:0] r_fifoExc;
  logic [ALEN-1:0] r_aq [DEPTH];

  logic [ILEN-1:0] r_lastInstr;
  logic [ALEN-1:0] r_lastAddr;
  logic [ALEN-1:0] r_lastNext;
  logic            r_lastExc;

  logic            w_fifoEmpty;
  logic            w_xfer;
  logic [SW-1:0]   w_occupancy;
  logic            w_credit;
  logic            w_aligned;
  logic            w_accept;
  logic            w_respLive;
  logic            w_respDrop;
  logic            w_fault;
  logic            w_push;
  logic [ILEN-1:0] w_pushData;
  logic [ALEN-1:0] w_pushAddr;
  logic            w_pushExc;

  function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A beat leaving this cycle frees its slot, so it counts as credit; this keeps one beat per cycle.
  assign w_fifoEmpty = (r_count == '0);
  assign w_xfer      = !w_fifoEmpty && !i_next_stalled;
  assign w_occupancy = SW'(r_inflight) + SW'(r_dropCnt) + SW'(r_count) - SW'(w_xfer);
  assign w_credit    = (w_occupancy < SW'(DEPTH));
  assign w_aligned   = (r_pc[1:0] == 2'b00);

  assign o_mem_req_valid = i_rst_n && !i_flush && (r_state == ST_FETCH) && w_credit && w_aligned;
  assign o_mem_req_addr  = r_pc;
  assign w_accept        = o_mem_req_valid && i_mem_req_ready;

  assign w_respDrop = i_mem_resp_valid && (r_dropCnt != '0) && !i_flush;
  assign w_respLive = i_mem_resp_valid && (r_dropCnt == '0) && !i_flush;

  // A misaligned PC produces one faulting beat once older fetches have drained.
  assign w_fault = (r_state == ST_FETCH) && !w_aligned && (r_inflight == '0)
                   && (r_count < CW'(DEPTH)) && !i_flush;

  assign w_push     = w_respLive || w_fault;
  assign w_pushData = w_fault ? '0 : i_mem_resp_data;
  assign w_pushAddr = w_fault ? r_pc : r_aq[r_aqRd];
  assign w_pushExc  = w_fault ? 1'b1 : i_mem_resp_error;

  // Control state: flush wins over every other event in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_FETCH;
      r_pc       <= RESET_PC;
      r_inflight <= '0;
      r_dropCnt  <= '0;
      r_count    <= '0;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_aqWr     <= '0;
      r_aqRd     <= '0;
    end else if (i_flush) begin
      r_state    <= ST_FETCH;
      r_pc       <= i_flush_addr;
      r_dropCnt  <= r_dropCnt + r_inflight - CW'(i_mem_resp_valid);
      r_inflight <= '0;
      r_count    <= '0;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_aqWr     <= '0;
      r_aqRd     <= '0;
    end else begin
      if (w_accept) begin
        r_pc   <= r_pc + ALEN'(4);
        r_aqWr <= ptrInc(r_aqWr);
      end
      if (w_fault) begin
        r_state <= ST_HALTED;
      end
      if (w_respDrop) begin
        r_dropCnt <= r_dropCnt - CW'(1);
      end
      if (w_respLive) begin
        r_aqRd <= ptrInc(r_aqRd);
      end
      if (w_push) begin
        r_wrPtr <= ptrInc(r_wrPtr);
      end
      if (w_xfer) begin
        r_rdPtr <= ptrInc(r_rdPtr);
      end
      r_inflight <= r_inflight + CW'(w_accept) - CW'(w_respLive);
      r_count    <= r_count + CW'(w_push) - CW'(w_xfer);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifoData[r_wrPtr] <= w_pushData;
      r_fifoAddr[r_wrPtr] <= w_pushAddr;
      r_fifoExc[r_wrPtr]  <= w_pushExc;
    end
    if (w_accept) begin
      r_aq[r_aqWr] <= r_pc;
    end
  end

  // Shadow of the most recent head so the outputs hold once the FIFO runs empty.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lastInstr <= '0;
      r_lastAddr  <= '0;
      r_lastNext  <= '0;
      r_lastExc   <= 1'b0;
    end else if (!w_fifoEmpty) begin
      r_lastInstr <= r_fifoData[r_rdPtr];
      r_lastAddr  <= r_fifoAddr[r_rdPtr];
      r_lastNext  <= r_fifoAddr[r_rdPtr] + ALEN'(4);
      r_lastExc   <= r_fifoExc[r_rdPtr];
    end
  end

  assign o_stall_next            = w_fifoEmpty;
  assign o_instruction           = w_fifoEmpty ? r_lastInstr : r_fifoData[r_rdPtr];
  assign o_instruction_addr      = w_fifoEmpty ? r_lastAddr  : r_fifoAddr[r_rdPtr];
  assign o_instruction_next_addr = w_fifoEmpty ? r_lastNext  : r_fifoAddr[r_rdPtr] + ALEN'(4);
  assign o_ifetch_exception      = w_fifoEmpty ? r_lastExc   : r_fifoExc[r_rdPtr];

endmodule

// File: tb/tb_fetch_stream.sv
// Scoreboard bench for fetch_stream: a pipelined memory model answers requests, the expected
// instruction stream is derived from the fetch PC sequence and flushes, and a monitor checks each beat.
module tb_fetch_stream;

  localparam int          ALEN     = 32;
  localparam int          ILEN     = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flushAddr = '0;
  logic        reqValid;
  logic        reqReady = 1'b0;
  logic [31:0] reqAddr;
  logic        respValid = 1'b0;
  logic [31:0] respData = '0;
  logic        respErr = 1'b0;
  logic [31:0] instr;
  logic [31:0] instrAddr;
  logic [31:0] instrNext;
  logic        fetchExc;
  logic        stallNext;
  logic        nextStalled = 1'b0;

  always #5 clk = ~clk;

  fetch_stream #(
    .ALEN(ALEN), .ILEN(ILEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_flush_addr(flushAddr),
    .o_mem_req_valid(reqValid), .i_mem_req_ready(reqReady), .o_mem_req_addr(reqAddr),
    .i_mem_resp_valid(respValid), .i_mem_resp_data(respData), .i_mem_resp_error(respErr),
    .o_instruction(instr), .o_instruction_addr(instrAddr),
    .o_instruction_next_addr(instrNext), .o_ifetch_exception(fetchExc),
    .o_stall_next(stallNext), .i_next_stalled(nextStalled)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic [31:0] nextAddr;
    logic        exc;
  } beat_t;

  typedef struct packed {
    logic [31:0] addr;
    int          due;
  } memReq_t;

  beat_t   expQ[$];
  memReq_t memQ[$];

  int errors = 0;
  int checks = 0;
  int cycNeg = 0;
  int relNeg = 0;
  int memLat = 1;
  int readyPct = 100;
  int haltViol = 0;
  int firstBeatCycle = -1;
  int beatsInWindow = 0;
  int totalBeats = 0;
  logic [31:0] modelPc = RESET_PC;
  bit modelHalted = 1'b0;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic memErr(input logic [31:0] a);
    return ((a >> 2) % 7) == 3;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic topUp();
    beat_t b;
    if (!modelHalted) begin
      while (expQ.size() < 8) begin
        b.instr    = memData(modelPc);
        b.addr     = modelPc;
        b.nextAddr = modelPc + 32'd4;
        b.exc      = memErr(modelPc);
        expQ.push_back(b);
        modelPc = modelPc + 32'd4;
      end
    end
  endtask

  task automatic modelFlush(input logic [31:0] fa);
    beat_t b;
    if (modelHalted) begin
      checkOutput("halt_no_req", haltViol, 0);
    end
    haltViol = 0;
    expQ.delete();
    if (fa[1:0] != 2'b00) begin
      b.instr    = '0;
      b.addr     = fa;
      b.nextAddr = fa + 32'd4;
      b.exc      = 1'b1;
      expQ.push_back(b);
      modelHalted = 1'b1;
    end else begin
      modelPc     = fa;
      modelHalted = 1'b0;
    end
  endtask

  task automatic applyStimulus(input bit stall, input bit doFlush, input logic [31:0] fa);
    @(posedge clk);
    #1;
    nextStalled = stall;
    flush       = doFlush;
    flushAddr   = fa;
    if (doFlush) begin
      modelFlush(fa);
    end
    topUp();
  endtask

  // Pipelined memory: fixed latency, in-order, one response per cycle, random ready.
  initial begin
    int memCyc;
    memReq_t m;
    memCyc = 0;
    forever begin
      @(negedge clk);
      memCyc++;
      if (!rst_n) begin
        memQ.delete();
        respValid = 1'b0;
        reqReady  = 1'b0;
      end else begin
        if (memQ.size() > 0 && memQ[0].due <= memCyc) begin
          m = memQ.pop_front();
          respValid = 1'b1;
          respData  = memData(m.addr);
          respErr   = memErr(m.addr);
        end else begin
          respValid = 1'b0;
          respData  = '0;
          respErr   = 1'b0;
        end
        reqReady = ($urandom_range(99) < readyPct);
        if (reqValid && reqReady) begin
          m.addr = reqAddr;
          m.due  = memCyc + memLat;
          memQ.push_back(m);
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every beat that will transfer at the next edge.
  initial begin
    beat_t e;
    beat_t held;
    bit holdPrev;
    int cyc;
    holdPrev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      cycNeg++;
      if (rst_n) begin
        if (modelHalted && reqValid) begin
          haltViol++;
        end
        if (holdPrev) begin
          checkOutput("hold_addr", instrAddr, held.addr);
          checkOutput("hold_instr", instr, held.instr);
          checkOutput("hold_exc", fetchExc, held.exc);
          checkOutput("hold_stall", stallNext, 0);
        end
        holdPrev = nextStalled && !stallNext && !flush;
        held.instr    = instr;
        held.addr     = instrAddr;
        held.nextAddr = instrNext;
        held.exc      = fetchExc;
        if (!stallNext && !nextStalled && !flush) begin
          cyc = cycNeg - relNeg;
          totalBeats++;
          if (firstBeatCycle < 0) begin
            firstBeatCycle = cyc;
          end
          if (cyc >= 5 && cyc <= 24) begin
            beatsInWindow++;
          end
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_beat: actual addr=%h required=no beat", instrAddr);
          end else begin
            e = expQ.pop_front();
            checkOutput("beat_addr", instrAddr, e.addr);
            checkOutput("beat_next_addr", instrNext, e.nextAddr);
            checkOutput("beat_instr", instr, e.instr);
            checkOutput("beat_exc", fetchExc, e.exc);
          end
        end
      end
    end
  end

  initial begin
    int r;
    logic [31:0] fa;
    repeat (3) @(negedge clk);
    checkOutput("reset_req_valid", reqValid, 0);
    checkOutput("reset_stall_next", stallNext, 1);
    checkOutput("reset_instr", instr, 0);
    checkOutput("reset_addr", instrAddr, 0);
    checkOutput("reset_next_addr", instrNext, 0);
    checkOutput("reset_exc", fetchExc, 0);

    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    relNeg = cycNeg;
    topUp();
    @(negedge clk);
    checkOutput("first_req_valid", reqValid, 1);
    checkOutput("first_req_addr", reqAddr, RESET_PC);

    // Zero-wait memory, no backpressure: first beat in cycle 3, then one per cycle.
    repeat (25) applyStimulus(1'b0, 1'b0, '0);
    checkOutput("first_beat_cycle", firstBeatCycle, 3);
    checkOutput("throughput_beats", beatsInWindow, 20);

    repeat (5) applyStimulus(1'b1, 1'b0, '0);
    @(negedge clk);
    checkOutput("stall_credit_exhausted", reqValid, 0);
    repeat (10) applyStimulus(1'b0, 1'b0, '0);

    memLat = 3;
    repeat (12) applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 32'h200);
    repeat (15) applyStimulus(1'b0, 1'b0, '0);

    applyStimulus(1'b0, 1'b1, 32'h202);
    repeat (12) applyStimulus(1'b0, 1'b0, '0);
    checkOutput("halt_beat_consumed", expQ.size(), 0);
    checkOutput("halt_stall_next", stallNext, 1);
    applyStimulus(1'b0, 1'b1, 32'h300);
    repeat (15) applyStimulus(1'b0, 1'b0, '0);

    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8);
    repeat (15) applyStimulus(1'b0, 1'b0, '0);

    for (int i = 0; i < 1500; i++) begin
      if (i % 150 == 0) begin
        memLat   = $urandom_range(1, 4);
        readyPct = $urandom_range(50, 100);
      end
      if ($urandom_range(39) == 0) begin
        r = $urandom_range(9);
        if (r <= 5) begin
          fa = 32'h1000 + {22'd0, 8'($urandom_range(255)), 2'b00};
        end else if (r <= 7) begin
          fa = 32'h2000 + {22'd0, 8'($urandom_range(255)), 2'b00} + 32'($urandom_range(1, 3));
        end else if (r == 8) begin
          fa = 32'hFFFF_FFF8;
        end else begin
          fa = {$urandom, 2'b00};
        end
        applyStimulus($urandom_range(3) == 0, 1'b1, fa);
      end else begin
        applyStimulus($urandom_range(3) == 0, 1'b0, '0);
      end
    end

    memLat   = 1;
    readyPct = 100;
    applyStimulus(1'b0, 1'b1, 32'h400);
    repeat (30) applyStimulus(1'b0, 1'b0, '0);
    checkOutput("beats_seen", (totalBeats > 200) ? 1 : 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
